// File: rtl/mul_pkg.sv
// Shared types and constants for the shift-add multiply sequencer.
package mul_pkg;

  localparam int MUL_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Shift-add datapath: latched multiplicand, multiplier shift register and a
// 2*WIDTH accumulator, advanced one bit per step.
module mul_shift_add
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     sum;

  // The carry out of the add becomes the new top bit after the right shift.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    acc_next = {sum, acc[WIDTH-1:1]};
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  // NOTE: the datapath registers are reset too, so a reset leaves no stale
  // operands or partial sums visible anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else if (load) begin
      a_q <= a_in;
      b_q <= b_in;
      acc <= '0;
    end else if (step) begin
      b_q <= {acc[0], b_q[WIDTH-1:1]};
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply sequencer for the Execute stage: stalls the pipeline
// for WIDTH shift-add steps, then presents the product for one cycle.
module mul_sequencer
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               mul_req,
  input  logic               flush,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               stall,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mul_state_e         state;
  mul_state_e         state_next;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               start;
  logic               zero_op;
  logic               last_step;
  logic [2*WIDTH-1:0] acc_next;

  assign start     = (state == IDLE) && mul_req && !flush;
  assign zero_op   = (op_a == '0) || (op_b == '0);
  assign last_step = (state == RUN) && !flush && (cnt == CNT_W'(1));

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(1)) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH);
    end else if (step) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Product only changes at a completed start: zero shortcut or final step.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      product <= '0;
    end else if (start && zero_op) begin
      product <= '0;
    end else if (last_step) begin
      product <= acc_next;
    end
  end

  mul_shift_add #(
    .WIDTH(WIDTH)
  ) u_shift_add (
    .clk     (CLK),
    .rst     (Reset),
    .load    (load),
    .step    (step),
    .a_in    (op_a),
    .b_in    (op_b),
    .acc_next(acc_next)
  );

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = mul_req && !flush && (state != DONE) && !Reset;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases plus random
// multiplies, compared cycle by cycle against a timing/arithmetic model.
module tb_mul_sequencer;

  localparam int W = 16;

  logic           CLK = 1'b0;
  logic           Reset;
  logic           mul_req;
  logic           flush;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           stall;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int             checks   = 0;
  int             failures = 0;
  logic [2*W-1:0] model_prod;

  mul_sequencer #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .Reset  (Reset),
    .mul_req(mul_req),
    .flush  (flush),
    .op_a   (op_a),
    .op_b   (op_b),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    mul_req = 1'b0;
    flush   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_stall", stall, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_product", product, model_prod);
      next_cycle();
    end
  endtask

  // kind: 0 = plain, 1 = flush in cycle 'at', 2 = reset pulse in cycle 'at'.
  // Cycle 0 is the first cycle mul_req is seen; inputs are driven just after
  // the rising edge and outputs sampled on the falling edge.
  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int kind, input int at);
    logic [2*W-1:0] prev;
    logic [2*W-1:0] full;
    bit             zero;
    bit             fl;
    bit             aborted;
    int             last;
    prev    = model_prod;
    full    = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    zero    = (a == '0) || (b == '0);
    last    = zero ? 1 : W + 1;
    aborted = 1'b0;
    op_a    = a;
    op_b    = b;
    mul_req = 1'b1;
    for (int c = 0; c <= last; c++) begin
      fl    = (kind == 1) && (c == at);
      flush = fl;
      if (c > 0) begin
        op_a = W'($urandom);
        op_b = W'($urandom);
      end
      if (kind == 2 && c == at) begin
        #1;
        Reset = 1'b1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        model_prod = '0;
        @(negedge CLK);
        Reset   = 1'b0;
        mul_req = 1'b0;
        next_cycle();
        idle(1);
        aborted = 1'b1;
        break;
      end
      @(negedge CLK);
      check("stall", stall, (!fl && c != last) ? 1 : 0);
      check("busy", busy, (!zero && c >= 1 && c <= W) ? 1 : 0);
      check("done", done, (c == last) ? 1 : 0);
      check("product", product, (c >= last) ? full : prev);
      next_cycle();
      if (fl) begin
        if (c >= last) model_prod = full;
        idle(1);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) model_prod = full;
  endtask

  initial begin
    Reset      = 1'b1;
    mul_req    = 1'b1;
    flush      = 1'b0;
    op_a       = 16'd3;
    op_b       = 16'd5;
    model_prod = '0;
    #2;
    check("reset_stall", stall, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    @(negedge CLK);
    Reset   = 1'b0;
    mul_req = 1'b0;
    next_cycle();
    idle(2);

    do_mul(16'd3, 16'd5, 0, 0);
    idle(1);
    do_mul(16'hFFFF, 16'hFFFF, 0, 0);
    idle(1);
    do_mul(16'd0, 16'd1234, 0, 0);
    idle(1);
    do_mul(16'd11, 16'd13, 0, 0);
    idle(1);
    do_mul(16'd500, 16'd600, 1, 5);
    idle(1);
    do_mul(16'd7, 16'd9, 0, 0);
    do_mul(16'd100, 16'd200, 0, 0);
    idle(1);
    do_mul(16'd42, 16'd17, 1, W + 1);
    idle(1);
    do_mul(16'd9, 16'd0, 1, 0);
    idle(1);
    do_mul(16'd321, 16'd123, 2, 8);
    do_mul(16'd321, 16'd123, 0, 0);
    idle(1);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           kind;
      ra   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      rb   = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_mul(ra, rb, kind, int'($urandom_range(0, W + 1)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle multiply sequencer for the Execute stage of the pipelined CPU. It replaces the free-running multiplier on a separate PLL clock with a shift-add unit on `CLK`. It captures operands when a multiply instruction reaches Execute, stalls the pipeline for the fixed iteration count, and presents the product for one cycle so the EX/MEM register can take it. It also accepts a pipeline flush that aborts an in-flight multiply.

## Interface
Parameters:
- `WIDTH`, 16: operand width. Product width is `2*WIDTH`.

Ports:
- `CLK`, in, 1: system clock. The block uses one clock only.
- `Reset`, in, 1: asynchronous, active-high reset.
- `mul_req`, in, 1: a multiply instruction is in Execute (decoded control bit). Held high by the stalled pipeline.
- `flush`, in, 1: synchronous pipeline flush (taken branch or jump). Aborts any operation.
- `op_a`, in, WIDTH: multiplicand (rs low bits).
- `op_b`, in, WIDTH: multiplier (rt low bits).
- `stall`, out, 1: freezes PC, IF/ID, ID/EX. Combinational.
- `busy`, out, 1: high in RUN state.
- `done`, out, 1: product valid this cycle. One-cycle pulse.
- `product`, out, 2*WIDTH: result. Held until the next start.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - If `flush`, stay in IDLE.
  - Else, if `mul_req`, on the edge:
    - latch `op_a`/`op_b`;
    - set acc = 0 and cnt = WIDTH;
    - go to RUN.
  - Zero shortcut: if `op_a`==0 or `op_b`==0, go straight to DONE with `product`=0. RUN is skipped.
- RUN, each edge:
  - If B[0], add A into acc[2W-1:W] with carry.
  - Shift {carry, acc, B} right by 1.
  - Decrement cnt.
  - When cnt reaches 1 at the edge, next state is DONE and `product` is loaded with the final acc.
- DONE: `done`=1 and `stall`=0, so the pipeline advances. Next state is IDLE unconditionally. A back-to-back multiply is seen in IDLE on the following cycle.
- `flush` in any state: next state is IDLE and no `done` is issued. `product` keeps its old value. Flush has priority over `mul_req`.
- `stall` = `mul_req` & ~`flush` & (state != DONE) & ~`Reset`.
- Operand changes during RUN are ignored, because the values were latched at start.
- Arithmetic is unsigned. The result is exact modulo 2^(2W); no overflow is possible.

## Timing
- Reset values: state IDLE, `product`=0, `done`=0, `busy`=0, `stall`=0, internal acc/B/cnt = 0.
- Normal operation, with `mul_req` first seen in cycle 0:
  - RUN occupies cycles 1..WIDTH.
  - DONE is cycle WIDTH+1.
  - `stall` is high for cycles 0..WIDTH, i.e. WIDTH+1 cycles.
  - Latency is WIDTH+1 cycles; throughput is one multiply per WIDTH+2 cycles.
- Zero operand: DONE in cycle 1, `stall` high in cycle 0 only.
- Reset asserted mid-RUN: immediate return to IDLE with reset values. `stall` drops in the same cycle.
- `flush` and DONE in the same cycle: `done` is still asserted, since the instruction already completed. Next state is IDLE.

## Structure
- Shared package `mul_pkg`: state enum (IDLE, RUN, DONE) and a default `WIDTH` constant.
- Counter width is $clog2(WIDTH+1).
- One sub-module, `mul_shift_add`: acc/B shift register with adder, driven by `load`/`step` enables from the FSM.
- The FSM, counter and output logic stay in `mul_sequencer`.

## Test plan
- Basic multiply: `op_a`=3, `op_b`=5, `mul_req` held until `done`. Expect:
  - `stall` high for 17 cycles;
  - `done` in cycle 17;
  - `product`=15.
- Max operands: `op_a`=`op_b`=16'hFFFF. Expect `product`=32'hFFFE0001 in cycle 17.
- Zero shortcut: `op_a`=0, `op_b`=1234. Expect:
  - `done` in cycle 1, `product`=0;
  - `stall` high one cycle only;
  - `busy` never high.
- Flush: `flush` asserted in cycle 5 of RUN. Expect:
  - IDLE next cycle;
  - no `done` pulse;
  - `product` unchanged from the prior result;
  - `stall` low in the flush cycle.
- Back-to-back: 7×9 followed immediately by 100×200. Expect:
  - `product`=63 at `done`;
  - one IDLE cycle;
  - second `done` 17 cycles later with `product`=20000.
- Reset mid-RUN: `Reset` pulsed in cycle 8. Expect:
  - `stall`, `busy`, `done`, `product` all 0 asynchronously;
  - a new request afterwards completes normally.
